psum_deskew_collector: RTL

PSUM_DESKEW_COLLECTOR -- requirements
Module: psum_deskew_collector

---
 rtl/psum_deskew_collector.sv | 144 ++++++++++++++
 1 files changed

// File: rtl/psum_deskew_collector.sv
// Re-aligns column-skewed partial sums from the bottom PE row into whole rows and
// buffers them in a first-word-fall-through FIFO. Define PSUM_DESKEW_OVF_EN to add the sticky ovf port.
module psum_deskew_collector #(
    parameter int unsigned PARTIAL_SUM_BW = 19,
    parameter int unsigned COLS           = 8,
    parameter int unsigned FIFO_DEPTH     = 4
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           clr,
    input  logic                           in_valid,
    input  logic [COLS*PARTIAL_SUM_BW-1:0] psum_in,
    output logic                           out_valid,
    input  logic                           out_ready,
    output logic [COLS*PARTIAL_SUM_BW-1:0] out_data
`ifdef PSUM_DESKEW_OVF_EN
    ,
    output logic                           ovf
`endif
);
    localparam int unsigned ROW_W = COLS * PARTIAL_SUM_BW;
    localparam int unsigned AW    = $clog2(FIFO_DEPTH);
    localparam int unsigned CW    = AW + 1;
    localparam int unsigned VS    = COLS - 1;

    logic [VS-1:0]    vsr_q, vsr_d;
    logic [ROW_W-1:0] row_c;

    // Row-valid marker travels alongside the skew; its last stage flags a complete row.
    always_comb begin
        vsr_d = '0;
        if (!clr) begin
            vsr_d[0] = in_valid;
            for (int unsigned k = 1; k < VS; k++) begin
                vsr_d[k] = vsr_q[k-1];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) vsr_q <= '0;
        else     vsr_q <= vsr_d;
    end

    // Column j is delayed COLS-1-j cycles so every column lands in the same cycle.
    for (genvar j = 0; j < COLS - 1; j++) begin : g_col
        localparam int unsigned D = COLS - 1 - j;
        logic [PARTIAL_SUM_BW-1:0] pipe_q [D];
        logic [PARTIAL_SUM_BW-1:0] pipe_d [D];

        always_comb begin
            pipe_d[0] = psum_in[j*PARTIAL_SUM_BW +: PARTIAL_SUM_BW];
            for (int unsigned k = 1; k < D; k++) begin
                pipe_d[k] = pipe_q[k-1];
            end
        end

        always_ff @(posedge clk) begin
            if (rst) begin
                for (int unsigned k = 0; k < D; k++) pipe_q[k] <= '0;
            end else begin
                pipe_q <= pipe_d;
            end
        end

        assign row_c[j*PARTIAL_SUM_BW +: PARTIAL_SUM_BW] = pipe_q[D-1];
    end

    assign row_c[(COLS-1)*PARTIAL_SUM_BW +: PARTIAL_SUM_BW] =
        psum_in[(COLS-1)*PARTIAL_SUM_BW +: PARTIAL_SUM_BW];

    logic [ROW_W-1:0] mem_q [FIFO_DEPTH];
    logic [ROW_W-1:0] mem_d [FIFO_DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             out_valid_q, out_valid_d;
    logic             wr_c, pop_c, full_c, push_c;

    // FIFO bookkeeping: a full FIFO still accepts a row when the head pops that cycle.
    always_comb begin
        full_c   = (count_q == CW'(FIFO_DEPTH));
        pop_c    = out_valid_q & out_ready;
        wr_c     = vsr_q[VS-1];
        push_c   = wr_c & ~clr & (~full_c | pop_c);
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push_c) begin
            mem_d[wr_ptr_q] = row_c;
            wr_ptr_d        = wr_ptr_q + AW'(1);
        end
        if (pop_c) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end
        case ({push_c, pop_c})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
        if (clr) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end
        out_valid_d = (count_d != '0);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            out_valid_q <= 1'b0;
        end else begin
            mem_q       <= mem_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = mem_q[rd_ptr_q];

`ifdef PSUM_DESKEW_OVF_EN
    logic ovf_q, ovf_d;

    // Sticky: only rst clears it, a flush leaves it alone.
    always_comb begin
        ovf_d = ovf_q | (wr_c & ~clr & full_c & ~pop_c);
    end

    always_ff @(posedge clk) begin
        if (rst) ovf_q <= 1'b0;
        else     ovf_q <= ovf_d;
    end

    assign ovf = ovf_q;
`endif

endmodule
